// File: rtl/coin_pkg.sv
// Shared constants and FSM state encoding for the coin transfer datapath.
// The state encoding is also used by the debug hex display.
package coin_pkg;

    localparam int DEF_BAL_W    = 8;
    localparam int DEF_KEY_W    = 8;
    localparam int DEF_PLAYER_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_SRC = 3'd1,
        ST_RD_DST = 3'd2,
        ST_CHECK  = 3'd3,
        ST_WR_SRC = 3'd4,
        ST_WR_DST = 3'd5,
        ST_DONE   = 3'd6
    } txn_state_t;

endpackage

// File: rtl/txn_check.sv
// Combinational acceptance test for a coin transfer.
// The destination sum is formed one bit wider so the carry flags overflow.
module txn_check #(
    parameter int BAL_W    = coin_pkg::DEF_BAL_W,
    parameter int KEY_W    = coin_pkg::DEF_KEY_W,
    parameter int PLAYER_W = coin_pkg::DEF_PLAYER_W
) (
    input  logic [KEY_W-1:0]    kreg,
    input  logic [KEY_W-1:0]    key,
    input  logic [PLAYER_W-1:0] src,
    input  logic [PLAYER_W-1:0] dst,
    input  logic [BAL_W-1:0]    amount,
    input  logic [BAL_W-1:0]    src_bal,
    input  logic [BAL_W-1:0]    dst_bal,
    output logic                ok
);

    logic [BAL_W:0] sum;

    assign sum = {1'b0, dst_bal} + {1'b0, amount};

    assign ok = (kreg == key)
             && (src != dst)
             && (amount <= src_bal)
             && !sum[BAL_W];

endmodule

// File: rtl/transaction_engine.sv
// Latches transfer operands, reads both balances and the key, validates,
// then writes both balances back and signals completion to main_control.
module transaction_engine
    import coin_pkg::*;
#(
    parameter int BAL_W    = DEF_BAL_W,
    parameter int KEY_W    = DEF_KEY_W,
    parameter int PLAYER_W = DEF_PLAYER_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                reset_others,
    input  logic                load_player,
    input  logic                load_amount,
    input  logic                load_key,
    input  logic [BAL_W-1:0]    data_in,
    input  logic                start_transaction,
    output logic                finished_transaction,
    output logic [PLAYER_W-1:0] mem_addr,
    output logic [BAL_W-1:0]    mem_wdata,
    output logic                mem_wren,
    input  logic [BAL_W-1:0]    mem_rdata,
    output logic [PLAYER_W-1:0] key_addr,
    input  logic [KEY_W-1:0]    key_rdata,
    output logic                accepted
);

    txn_state_t          state;
    logic [PLAYER_W-1:0] src;
    logic [PLAYER_W-1:0] dst;
    logic [BAL_W-1:0]    amount;
    logic [KEY_W-1:0]    key;
    logic [KEY_W-1:0]    kreg;
    logic [BAL_W-1:0]    src_bal;
    logic [BAL_W-1:0]    dst_bal;
    logic                ok;

    assign key_addr = src;

    // In CHECK the destination balance is still on mem_rdata.
    txn_check #(
        .BAL_W    (BAL_W),
        .KEY_W    (KEY_W),
        .PLAYER_W (PLAYER_W)
    ) u_check (
        .kreg    (kreg),
        .key     (key),
        .src     (src),
        .dst     (dst),
        .amount  (amount),
        .src_bal (src_bal),
        .dst_bal (mem_rdata),
        .ok      (ok)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                <= ST_IDLE;
            src                  <= '0;
            dst                  <= '0;
            amount               <= '0;
            key                  <= '0;
            kreg                 <= '0;
            src_bal              <= '0;
            dst_bal              <= '0;
            mem_addr             <= '0;
            mem_wdata            <= '0;
            mem_wren             <= 1'b0;
            finished_transaction <= 1'b0;
            accepted             <= 1'b0;
        end else if (!reset_others) begin
            state                <= ST_IDLE;
            src                  <= '0;
            dst                  <= '0;
            amount               <= '0;
            key                  <= '0;
            mem_addr             <= '0;
            mem_wdata            <= '0;
            mem_wren             <= 1'b0;
            finished_transaction <= 1'b0;
        end else begin
            mem_wren  <= 1'b0;
            mem_wdata <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (load_player) begin
                        src <= data_in[PLAYER_W-1:0];
                        dst <= data_in[2*PLAYER_W-1:PLAYER_W];
                    end
                    if (load_amount) amount <= data_in;
                    if (load_key) key <= data_in[KEY_W-1:0];
                    mem_addr             <= src;
                    finished_transaction <= 1'b0;
                    if (start_transaction) state <= ST_RD_SRC;
                end
                ST_RD_SRC: begin
                    kreg     <= key_rdata;
                    mem_addr <= dst;
                    state    <= ST_RD_DST;
                end
                ST_RD_DST: begin
                    src_bal <= mem_rdata;
                    state   <= ST_CHECK;
                end
                ST_CHECK: begin
                    dst_bal <= mem_rdata;
                    if (ok) begin
                        mem_addr  <= src;
                        mem_wdata <= src_bal - amount;
                        mem_wren  <= 1'b1;
                        state     <= ST_WR_SRC;
                    end else begin
                        accepted             <= 1'b0;
                        finished_transaction <= 1'b1;
                        state                <= ST_DONE;
                    end
                end
                ST_WR_SRC: begin
                    mem_addr  <= dst;
                    mem_wdata <= dst_bal + amount;
                    mem_wren  <= 1'b1;
                    accepted  <= 1'b1;
                    state     <= ST_WR_DST;
                end
                ST_WR_DST: begin
                    finished_transaction <= 1'b1;
                    state                <= ST_DONE;
                end
                ST_DONE: begin
                    if (!start_transaction) begin
                        finished_transaction <= 1'b0;
                        mem_addr             <= src;
                        state                <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transaction_engine.sv
// Directed bench for transaction_engine with a transfer-level reference model.
// Balance and key memories are modelled as 1-cycle-latency synchronous RAMs.
module tb_transaction_engine;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       reset_others = 1'b1;
    logic       load_player = 1'b0;
    logic       load_amount = 1'b0;
    logic       load_key = 1'b0;
    logic [7:0] data_in = '0;
    logic       start_transaction = 1'b0;
    logic       finished_transaction;
    logic [1:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_wren;
    logic [7:0] mem_rdata;
    logic [1:0] key_addr;
    logic [7:0] key_rdata;
    logic       accepted;

    transaction_engine dut (
        .clock                (clock),
        .reset                (reset),
        .reset_others         (reset_others),
        .load_player          (load_player),
        .load_amount          (load_amount),
        .load_key             (load_key),
        .data_in              (data_in),
        .start_transaction    (start_transaction),
        .finished_transaction (finished_transaction),
        .mem_addr             (mem_addr),
        .mem_wdata            (mem_wdata),
        .mem_wren             (mem_wren),
        .mem_rdata            (mem_rdata),
        .key_addr             (key_addr),
        .key_rdata            (key_rdata),
        .accepted             (accepted)
    );

    always #5 clock = ~clock;

    logic [7:0] bal    [4];
    logic [7:0] keytab [4];

    always @(posedge clock) begin
        mem_rdata <= bal[mem_addr];
        key_rdata <= keytab[key_addr];
        if (mem_wren) bal[mem_addr] = mem_wdata;
    end

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    logic       tracking = 1'b0;
    int         start_edge = 0;
    logic       m_ok = 1'b0;
    logic       m_acc = 1'b0;
    int         m_src, m_dst, m_amt, m_sbal, m_dbal;

    // Outputs as a function of cycles elapsed since start was raised.
    always @(negedge clock) begin
        int k;
        logic e_wren, e_fin, e_acc;
        if (tracking) begin
            k      = edge_cnt - start_edge;
            e_wren = m_ok && (k == 4 || k == 5);
            e_fin  = k >= (m_ok ? 6 : 4);
            if (m_ok) e_acc = (k >= 5) ? 1'b1 : m_acc;
            else      e_acc = (k >= 4) ? 1'b0 : m_acc;
            chk("mem_wren", mem_wren, e_wren);
            chk("finished", finished_transaction, e_fin);
            chk("accepted", accepted, e_acc);
            chk("key_addr", key_addr, m_src);
            if (e_wren) begin
                chk("wr_addr", mem_addr, (k == 4) ? m_src : m_dst);
                chk("wr_data", mem_wdata,
                    (k == 4) ? m_sbal - m_amt : m_dbal + m_amt);
            end
        end
    end

    task automatic load_ops(input int s, input int d, input int a,
                            input int kv);
        @(posedge clock); #1;
        load_player = 1'b1;
        data_in = 8'((d << 2) | s);
        @(posedge clock); #1;
        load_player = 1'b0;
        load_amount = 1'b1;
        data_in = 8'(a);
        @(posedge clock); #1;
        load_amount = 1'b0;
        load_key = 1'b1;
        data_in = 8'(kv);
        @(posedge clock); #1;
        load_key = 1'b0;
        data_in = '0;
    endtask

    task automatic run_txn(input int s, input int d, input int a,
                           input int kv, input int hold);
        int lat;
        load_ops(s, d, a, kv);
        m_src  = s;
        m_dst  = d;
        m_amt  = a;
        m_sbal = bal[s];
        m_dbal = bal[d];
        m_ok   = (keytab[s] == 8'(kv)) && (s != d) && (a <= m_sbal)
              && (m_dbal + a <= 255);
        @(posedge clock); #1;
        start_transaction = 1'b1;
        start_edge = edge_cnt;
        tracking = 1'b1;
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!finished_transaction && lat < 20);
        chk("latency", lat, m_ok ? 6 : 4);
        for (int i = 0; i < hold; i++) begin
            load_player = 1'b1;
            data_in = 8'((s << 2) | d) ^ 8'h0f;
            @(posedge clock); #1;
        end
        load_player = 1'b0;
        data_in = '0;
        start_transaction = 1'b0;
        @(posedge clock); #1;
        tracking = 1'b0;
        chk("finished_drop", finished_transaction, 0);
        chk("load_in_done_ignored", key_addr, s);
        if (m_ok) begin
            chk("bal_src", bal[s], m_sbal - a);
            chk("bal_dst", bal[d], m_dbal + a);
        end else begin
            chk("bal_src_kept", bal[s], m_sbal);
            chk("bal_dst_kept", bal[d], m_dbal);
        end
        m_acc = m_ok;
    endtask

    initial begin
        bal[0] = 8'd0;    bal[1] = 8'd50;
        bal[2] = 8'd10;   bal[3] = 8'd250;
        keytab[0] = 8'h11; keytab[1] = 8'hA5;
        keytab[2] = 8'h3C; keytab[3] = 8'h77;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_finished", finished_transaction, 0);
        chk("rst_wren", mem_wren, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_key_addr", key_addr, 0);
        chk("rst_accepted", accepted, 0);
        reset = 1'b0;

        run_txn(1, 2, 20, 8'hA5, 0);
        chk("t1_src_30", bal[1], 30);
        chk("t1_dst_30", bal[2], 30);
        chk("t1_accepted", accepted, 1);

        run_txn(1, 2, 20, 8'hA4, 0);
        chk("t2_accepted", accepted, 0);

        bal[1] = 8'd5;
        run_txn(1, 2, 6, 8'hA5, 0);
        chk("t3_short_rej", accepted, 0);
        bal[1] = 8'd6;
        run_txn(1, 2, 6, 8'hA5, 0);
        chk("t3_exact_src0", bal[1], 0);
        chk("t3_exact_dst", bal[2], 36);

        bal[1] = 8'd50;
        run_txn(1, 3, 10, 8'hA5, 0);
        chk("t4_ovf_rej", accepted, 0);
        run_txn(1, 3, 5, 8'hA5, 0);
        chk("t4_max_255", bal[3], 255);
        run_txn(3, 3, 1, 8'h77, 0);
        chk("t4_self_rej", accepted, 0);

        run_txn(1, 2, 0, 8'hA5, 3);
        chk("t6_zero_acc", accepted, 1);
        chk("t6_zero_src", bal[1], 45);

        // reset_others asserted while the FSM sits in CHECK.
        load_ops(1, 2, 5, 8'hA5);
        @(posedge clock); #1;
        start_transaction = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset_others = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("ro_wren", mem_wren, 0);
            chk("ro_finished", finished_transaction, 0);
            chk("ro_key_addr", key_addr, 0);
            chk("ro_accepted", accepted, 1);
        end
        start_transaction = 1'b0;
        reset_others = 1'b1;
        @(posedge clock); #1;
        chk("ro_bal1", bal[1], 45);
        chk("ro_bal2", bal[2], 36);

        // Async reset asserted during WR_SRC.
        load_ops(1, 2, 5, 8'hA5);
        @(posedge clock); #1;
        start_transaction = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk("mr_in_wr_src", mem_wren, 1);
        reset = 1'b1;
        #1;
        chk("mr_wren", mem_wren, 0);
        chk("mr_addr", mem_addr, 0);
        chk("mr_wdata", mem_wdata, 0);
        chk("mr_finished", finished_transaction, 0);
        chk("mr_accepted", accepted, 0);
        @(posedge clock); #1;
        start_transaction = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        chk("mr_bal1", bal[1], 45);
        chk("mr_key_addr", key_addr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
